// File: rtl/clk_slow_mon.sv
// Divided-clock monitor: synchronises clk_slow into clk_in, measures its period and qualifies it
// through an IDLE/ACQ/LOCKED/LOST state machine. Optional duty-cycle check: CLK_SLOW_MON_DUTY_EN.
//
//   state  | meaning
//   IDLE   | no usable edge history; first rise only starts a measurement window
//   ACQ    | counting consecutive in-tolerance periods towards lock
//   LOCKED | divided clock qualified; locked output high
//   LOST   | lock dropped (bad period or timeout); sticky lost flag set
module clk_slow_mon #(
    parameter int EXP_PERIOD = 42,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 84,
    parameter int CNT_W      = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clk_slow,
    input  logic             clr_lost,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             lost
`ifdef CLK_SLOW_MON_DUTY_EN
    ,
    output logic [CNT_W-1:0] duty_hi,
    output logic             duty_err
`endif
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TOL_LO   = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] TOL_HI   = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
    localparam logic [GW-1:0]    GOOD_ONE = GW'(1);
    localparam logic [GW-1:0]    GOOD_TOP = GW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        LOST   = 2'd3
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    good_cnt;
    logic [CNT_W-1:0] measured;
    logic             in_tol;
    logic             timeout;
    logic             capture;
    logic             duty_bad;
    logic             enter_lost;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            s1         <= clk_slow;
            s2         <= s1;
            s3         <= s2;
            rise_pulse <= s2 & ~s3;
            fall_pulse <= ~s2 & s3;
        end
    end

    // cnt holds (cycles since last rise - 1), so the rise-to-rise distance is cnt + 1
    assign measured = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
    assign in_tol   = (measured >= TOL_LO) && (measured <= TOL_HI);
    assign timeout  = !rise_pulse && (cnt == TMO);
    assign capture  = rise_pulse && ((state == ACQ) || (state == LOCKED));

`ifdef CLK_SLOW_MON_DUTY_EN
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W+1:0] two_hi;
    logic [CNT_W+1:0] meas_w;
    logic [CNT_W+1:0] duty_diff;

    localparam logic [CNT_W+1:0] DUTY_LIM = (CNT_W+2)'(2 * TOL);

    assign two_hi    = {1'b0, duty_hi, 1'b0};
    assign meas_w    = {2'b00, measured};
    assign duty_diff = (two_hi > meas_w) ? (two_hi - meas_w) : (meas_w - two_hi);
    assign duty_bad  = duty_diff > DUTY_LIM;

    // s3 is aligned with the strobes, so hi_cnt spans rise_pulse to fall_pulse inclusive of the rise cycle
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt   <= '0;
            duty_hi  <= '0;
            duty_err <= 1'b0;
        end else begin
            if (rise_pulse) begin
                hi_cnt <= CNT_ONE;
            end else if (s3 && (hi_cnt != CNT_MAX)) begin
                hi_cnt <= hi_cnt + CNT_ONE;
            end
            if (fall_pulse) begin
                duty_hi <= hi_cnt;
            end
            duty_err <= capture && duty_bad;
        end
    end
`else
    assign duty_bad = 1'b0;
`endif

    assign enter_lost = (state == LOCKED) &&
                        ((rise_pulse && (!in_tol || duty_bad)) || timeout);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            good_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            lost       <= 1'b0;
        end else begin
            period_vld <= capture;
            if (capture) begin
                period <= measured;
            end

            // restart the window on a lock timeout so LOST gets its own full timeout before IDLE
            if (rise_pulse) begin
                cnt <= '0;
            end else if (timeout && (state == LOCKED)) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end

            if (enter_lost) begin
                lost <= 1'b1;
            end else if (clr_lost) begin
                lost <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise_pulse) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end
                end
                ACQ: begin
                    if (rise_pulse) begin
                        if (in_tol) begin
                            good_cnt <= good_cnt + GOOD_ONE;
                            if (good_cnt == GOOD_TOP) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
                LOCKED: begin
                    if (enter_lost) begin
                        state  <= LOST;
                        locked <= 1'b0;
                    end
                end
                LOST: begin
                    if (rise_pulse) begin
                        state    <= ACQ;
                        good_cnt <= '0;
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
